// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg: transmitter state encoding and PS/2 command bytes
package ps2_host_tx_pkg;
  typedef enum logic [2:0] {
    IDLE, INHIBIT, START, DATA, PARITY, STOP, ACK, WAIT_IDLE
  } state_t;
  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] RSP_ACK     = 8'hFA;
endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: pin synchroniser, clock agreement filter and falling-edge strobe
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_raw,
  input  logic data_raw,
  output logic clk_f,
  output logic data_s,
  output logic fall
);
  localparam int W = $clog2(FILTER_LEN + 1);
  logic [1:0] clk_sync, data_sync;
  logic [W-1:0] run;
  always_ff @(posedge clk)
    if (reset) begin
      clk_sync <= 2'b11;
      data_sync <= 2'b11;
      run <= '0;
      clk_f <= 1'b1;
      fall <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], clk_raw};
      data_sync <= {data_sync[0], data_raw};
      fall <= 1'b0;
      if (clk_sync[1] == clk_f)
        run <= '0;
      else if (run == W'(FILTER_LEN - 1)) begin
        run <= '0;
        clk_f <= clk_sync[1];
        fall <= ~clk_sync[1];
      end else
        run <= run + 1'b1;
    end
  assign data_s = data_sync[1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter with odd parity and ACK check
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_LEN = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       kb_clk_in,
  input  logic       kb_data_in,
  output logic       kb_clk_oe,
  output logic       kb_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err
);
  localparam int CW = $clog2((TIMEOUT_CYCLES > INHIBIT_CYCLES ? TIMEOUT_CYCLES : INHIBIT_CYCLES) + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] bitcnt, bitcnt_n;
  logic [8:0] sh, sh_n;
  logic data_oe_n, ack_r, ack_r_n, clk_f, data_s, fall, watch;
  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk(clk),
    .reset(reset),
    .clk_raw(kb_clk_in),
    .data_raw(kb_data_in),
    .clk_f(clk_f),
    .data_s(data_s),
    .fall(fall)
  );
  assign watch = !(state inside {IDLE, INHIBIT});
  assign err = watch && cnt == CW'(TIMEOUT_CYCLES);
  assign tx_ready = state == IDLE;
  assign busy = ~tx_ready;
  assign kb_clk_oe = state == INHIBIT;
  assign ack_ok = done & ack_r;
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      bitcnt <= '0;
      sh <= '0;
      kb_data_oe <= 1'b0;
      ack_r <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bitcnt <= bitcnt_n;
      sh <= sh_n;
      kb_data_oe <= data_oe_n;
      ack_r <= ack_r_n;
    end
  always_comb begin
    state_n = state;
    cnt_n = (fall && watch) ? '0 : cnt + 1'b1;
    bitcnt_n = bitcnt;
    sh_n = sh;
    data_oe_n = kb_data_oe;
    ack_r_n = ack_r;
    done = 1'b0;
    if (err) begin
      state_n = IDLE;
      cnt_n = '0;
      data_oe_n = 1'b0;
    end else
      case (state)
        IDLE: begin
          cnt_n = '0;
          if (tx_valid) begin
            sh_n = {~^tx_data, tx_data};
            bitcnt_n = '0;
            state_n = INHIBIT;
          end
        end
        INHIBIT:
          if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
            cnt_n = '0;
            data_oe_n = 1'b1;
            state_n = START;
          end
        START:
          if (fall) begin
            data_oe_n = ~sh[0];
            sh_n = sh >> 1;
            bitcnt_n = 4'd1;
            state_n = DATA;
          end
        DATA:
          if (fall) begin
            data_oe_n = ~sh[0];
            sh_n = sh >> 1;
            bitcnt_n = bitcnt + 1'b1;
            state_n = bitcnt == 4'd8 ? PARITY : DATA;
          end
        PARITY:
          if (fall) begin
            data_oe_n = 1'b0;
            state_n = STOP;
          end
        STOP: state_n = fall ? ACK : STOP;
        ACK: begin
          ack_r_n = ~data_s;
          state_n = WAIT_IDLE;
        end
        WAIT_IDLE:
          if (clk_f && data_s) begin
            done = 1'b1;
            state_n = IDLE;
          end
        default: state_n = IDLE;
      endcase
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with a PS/2 device model clocking at a 40-cycle period
module tb_ps2_host_tx;
  logic clk = 0, reset = 1, tx_valid = 0, dev_clk = 1, dev_data = 1;
  logic [7:0] tx_data = 8'h00;
  logic tx_ready, kb_clk_in, kb_data_in, kb_clk_oe, kb_data_oe, busy, done, ack_ok, err;
  int vectors = 0, miscompares = 0, done_cnt = 0, err_cnt = 0;
  assign kb_clk_in = dev_clk & ~kb_clk_oe;
  assign kb_data_in = dev_data & ~kb_data_oe;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) err_cnt++;
  end
  ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(500), .FILTER_LEN(2)) dut (
    .clk(clk),
    .reset(reset),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .kb_clk_in(kb_clk_in),
    .kb_data_in(kb_data_in),
    .kb_clk_oe(kb_clk_oe),
    .kb_data_oe(kb_data_oe),
    .busy(busy),
    .done(done),
    .ack_ok(ack_ok),
    .err(err)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b, output int inh);
    tx_data = b;
    tx_valid = 1;
    tick;
    tx_valid = 0;
    vectors++;
    if (kb_clk_oe !== 1'b1) begin
      miscompares++;
      $display("FAIL accept_latency %h: kb_clk_oe=%b want 1", b, kb_clk_oe);
    end
    inh = 0;
    while (kb_clk_oe === 1'b1 && inh < 100) begin
      inh++;
      tick;
    end
  endtask
  task automatic dev_frame(input logic ack, input logic glitch, input logic poke, output logic [10:0] bits);
    bits = '0;
    bits[0] = kb_data_in;
    for (int i = 1; i <= 11; i++) begin
      repeat (10) tick;
      if (i == 11 && ack) dev_data = 0;
      if (glitch && i == 5) begin
        dev_clk = 0;
        tick;
        dev_clk = 1;
      end
      if (poke && i == 5) begin
        tx_data = 8'h55;
        tx_valid = 1;
        tick;
        tx_valid = 0;
      end
      repeat (10) tick;
      dev_clk = 0;
      repeat (20) tick;
      dev_clk = 1;
      if (i <= 10) bits[i] = kb_data_in;
    end
    if (ack) begin
      repeat (10) tick;
      dev_data = 1;
    end
  endtask
  task automatic wait_done(output int n, output logic a, output logic e);
    n = 0;
    while (done !== 1'b1 && n < 300) begin
      n++;
      tick;
    end
    a = ack_ok;
    e = err;
  endtask
  task automatic test_reset;
    reset = 1;
    repeat (3) tick;
    vectors++;
    if ({kb_clk_oe, kb_data_oe, tx_ready, busy, done, ack_ok, err} !== 7'b0010000) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want 0010000", {kb_clk_oe, kb_data_oe, tx_ready, busy, done, ack_ok, err});
    end
    reset = 0;
    repeat (5) tick;
    vectors++;
    if (tx_ready !== 1'b1 || kb_clk_oe !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: tx_ready=%b kb_clk_oe=%b want 1 0", tx_ready, kb_clk_oe);
    end
  endtask
  task automatic test_frame(input string name, input logic [7:0] b, input logic ack,
                            input logic [10:0] exp_bits, input logic glitch, input logic poke);
    int inh, n, d0, e0, bz;
    logic [10:0] bits;
    logic a, e;
    d0 = done_cnt;
    e0 = err_cnt;
    send(b, inh);
    vectors++;
    if (inh != 20) begin
      miscompares++;
      $display("FAIL %s inhibit_len: got %0d want 20", name, inh);
    end
    vectors++;
    if (kb_data_oe !== 1'b1) begin
      miscompares++;
      $display("FAIL %s start_bit: kb_data_oe=%b want 1", name, kb_data_oe);
    end
    dev_frame(ack, glitch, poke, bits);
    vectors++;
    if (bits !== exp_bits) begin
      miscompares++;
      $display("FAIL %s bits: got %h want %h", name, bits, exp_bits);
    end
    wait_done(n, a, e);
    vectors++;
    if (n >= 300) begin
      miscompares++;
      $display("FAIL %s done_timeout: no done in %0d cycles", name, n);
    end
    vectors++;
    if (a !== ack || e !== 1'b0) begin
      miscompares++;
      $display("FAIL %s ack_ok/err: got %b%b want %b0", name, a, e, ack);
    end
    tick;
    vectors++;
    if (tx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s ready_after_done: got %b want 1", name, tx_ready);
    end
    bz = 0;
    repeat (60) begin
      tick;
      if (busy !== 1'b0) bz++;
    end
    vectors++;
    if (done_cnt - d0 != 1 || err_cnt != e0 || bz != 0) begin
      miscompares++;
      $display("FAIL %s done_count: dones=%0d errs=%0d busy_cycles=%0d want 1 0 0", name, done_cnt - d0, err_cnt - e0, bz);
    end
  endtask
  task automatic test_timeout;
    int n, d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'hF4, n);
    while (err !== 1'b1 && n < 1000) begin
      n++;
      tick;
    end
    vectors++;
    if (n < 519 || n > 523) begin
      miscompares++;
      $display("FAIL timeout_latency: got %0d want 521 +-2", n);
    end
    tick;
    vectors++;
    if ({kb_clk_oe, kb_data_oe, tx_ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL timeout_release: oe/ready got %b want 001", {kb_clk_oe, kb_data_oe, tx_ready});
    end
    repeat (5) tick;
    vectors++;
    if (done_cnt != d0 || err_cnt - e0 != 1) begin
      miscompares++;
      $display("FAIL timeout_pulses: dones=%0d errs=%0d want 0 1", done_cnt - d0, err_cnt - e0);
    end
  endtask
  task automatic test_reset_mid;
    int inh;
    send(8'h00, inh);
    repeat (3) begin
      repeat (20) tick;
      dev_clk = 0;
      repeat (20) tick;
      dev_clk = 1;
    end
    repeat (5) tick;
    vectors++;
    if (busy !== 1'b1 || kb_data_oe !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_frame_state: busy=%b kb_data_oe=%b want 1 1", busy, kb_data_oe);
    end
    reset = 1;
    tick;
    vectors++;
    if ({kb_clk_oe, kb_data_oe, tx_ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL mid_reset: oe/ready got %b want 001", {kb_clk_oe, kb_data_oe, tx_ready});
    end
    reset = 0;
    repeat (30) tick;
    test_frame("f4_after_reset", 8'hF4, 1'b1, 11'h5E8, 1'b0, 1'b0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_frame("ed_ack", 8'hED, 1'b1, 11'h7DA, 1'b0, 1'b0);
    test_frame("zero_ack", 8'h00, 1'b1, 11'h600, 1'b0, 1'b0);
    test_frame("ff_noack", 8'hFF, 1'b0, 11'h7FE, 1'b0, 1'b0);
    test_timeout;
    repeat (20) tick;
    test_reset_mid;
    test_frame("ed_glitch_poke", 8'hED, 1'b1, 11'h7DA, 1'b1, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It is the outbound counterpart of the keyboard receiver, and it sends command bytes to the keyboard: 0xED LED set, 0xFF reset, 0xF4 enable. It drives the open-drain kb_clk/kb_data lines through output-enable pins, serialises one byte per request with odd parity, and checks the device ACK. It sits beside keyboard in the top level and shares the physical PS/2 pins.

Parameters:
- INHIBIT_CYCLES, 12000, clk cycles kb_clk is held low before the start bit (≥100 µs at 100 MHz).
- TIMEOUT_CYCLES, 2000000, max clk cycles between device clock falling edges, or before the first one (20 ms).
- FILTER_LEN, 8, consecutive equal samples needed before the filtered kb_clk changes.

Ports:
- clk  in  1  system clock (100 MHz, undivided)
- reset  in  1  synchronous, active-high
- tx_data  in  8  byte to send
- tx_valid  in  1  request; accepted when tx_valid && tx_ready
- tx_ready  out  1  high only in IDLE
- kb_clk_in  in  1  raw pin sample, asynchronous
- kb_data_in  in  1  raw pin sample, asynchronous
- kb_clk_oe  out  1  1 = pull kb_clk low, 0 = release
- kb_data_oe  out  1  1 = pull kb_data low, 0 = release
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the frame completes
- ack_ok  out  1  valid with done; 1 = device ACK seen
- err  out  1  one-cycle pulse on timeout

Behaviour:
- Reset, or any reset cycle mid-operation:
  - state goes to IDLE.
  - kb_clk_oe=0, kb_data_oe=0, tx_ready=1, busy=0, done=0, ack_ok=0, err=0.
  - All counters and the shift register clear.
- Input conditioning:
  - 2-flop synchroniser on both pins.
  - kb_clk goes through a FILTER_LEN-sample agreement filter.
  - fall = filtered clock 1→0, a one-cycle strobe.
- Parity: par = ~^tx_data (odd parity), latched at accept together with tx_data.
- IDLE:
  - On accept, latch the byte, clear cnt, go to INHIBIT.
  - tx_valid while not ready is ignored; no queueing.
- INHIBIT:
  - kb_clk_oe=1.
  - After INHIBIT_CYCLES cycles, set kb_data_oe=1 (start bit) and go to START.
  - In START the first cycle releases the clock (kb_clk_oe=0); data stays low.
- START: wait for fall; on fall, drive bit0 and go to DATA with bitcnt=1.
- DATA:
  - Each fall drives the next bit, LSB first: kb_data_oe = ~bit.
  - After bit7 has been driven, the next fall drives par and the state goes to PARITY.
- PARITY: on fall, release data (stop bit, kb_data_oe=0), go to STOP.
- STOP: on fall, go to ACK.
- ACK:
  - On the first cycle, sample the synchronised kb_data and set ack_ok_r = ~kb_data.
  - Go to WAIT_IDLE.
- WAIT_IDLE:
  - Wait until filtered kb_clk=1 and synced kb_data=1.
  - Then pulse done=1 with ack_ok=ack_ok_r for that cycle, and return to IDLE.
  - A missing ACK is not an error; it is reported as done with ack_ok=0.
- Timeout:
  - The watchdog counts from START through WAIT_IDLE and clears on every fall.
  - When it reaches TIMEOUT_CYCLES: pulse err, release both lines, go to IDLE; done is not pulsed.
- Data changes only on fall, so data is stable while the device samples on the rising edge.
- Latency: accept to first line activity = 1 cycle (kb_clk_oe rises the cycle after accept).

Decomposition:
- Shared include/package holds:
  - state encodings IDLE, INHIBIT, START, DATA, PARITY, STOP, ACK, WAIT_IDLE (3 bits);
  - PS/2 command constants CMD_SET_LED=8'hED, CMD_RESET=8'hFF, CMD_ENABLE=8'hF4, RSP_ACK=8'hFA.
- One sub-module, ps2_line_filter: synchroniser, FILTER_LEN filter and falling-edge strobe. The same filter is reusable by keyboard.
- Top level: keyboard RX and ps2_host_tx share kb_clk/kb_data. The top drives a pin low when its oe is high, else high-Z.

Test Plan:
(Simulation uses INHIBIT_CYCLES=20, FILTER_LEN=2, TIMEOUT_CYCLES=500. The device model clocks at a 40-cycle period, samples data on rising edges and drives the ACK.)
1. Send 0xED with a device ACK:
   - kb_clk_oe high for exactly 20 cycles.
   - Sampled bits 0 | 1,0,1,1,0,1,1,1 | parity 1 | stop 1.
   - done=1 with ack_ok=1; tx_ready=1 the next cycle.
2. Send 0x00: parity bit sampled as 1, stop as 1; done with ack_ok=1.
3. Send 0xFF with no ACK (data left high on the 11th clock) → done=1, ack_ok=0, err=0.
4. Device never clocks → err pulses at 20+1+500 (±2) cycles after accept; oe lines both 0; no done.
5. Reset asserted after 3 data bits → the next cycle has kb_clk_oe=0, kb_data_oe=0, tx_ready=1. A new send of 0xF4 then completes correctly.
6. Robustness:
   - A 1-cycle glitch low on kb_clk_in during DATA is not counted; the frame still decodes as 0xED.
   - tx_valid pulsed during busy is ignored; exactly one done.
